// File: rtl/regmem_pkg.sv
// ---------------------------------------------------------------------------
// regmem_pkg
//   Shared definitions for the register-based memory regfile_mem.
//   - REGMEM_WIDTH / REGMEM_DEPTH : default word width and word count
//   - addr_ok()                   : true when an address selects a real word
// No ports (package).
// ---------------------------------------------------------------------------
package regmem_pkg;

    localparam int unsigned REGMEM_WIDTH = 8;
    localparam int unsigned REGMEM_DEPTH = 16;

    // DEPTH need not be a power of two, so an address that fits in AW bits
    // can still be past the last word.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage : regmem_pkg

// File: rtl/regmem_word.sv
// ---------------------------------------------------------------------------
// regmem_word
//   One WIDTH-bit storage word: a bank of enabled flip-flops with an
//   asynchronous active-low clear.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low clear
//   en     in   1      load enable
//   d      in   WIDTH  data to load
//   q      out  WIDTH  stored word
// ---------------------------------------------------------------------------
module regmem_word
    import regmem_pkg::*;
#(
    parameter int unsigned WIDTH = REGMEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : regmem_word

// File: rtl/regfile_mem.sv
// ---------------------------------------------------------------------------
// regfile_mem
//   DEPTH words of WIDTH bits built from regmem_word cells, with one
//   synchronous write port and one registered read port (latency 1).
//   Out-of-range accesses are flagged one cycle later on wr_err / rd_err.
//
// Configuration macro: RD_BYPASS_EN
//   defined   : same-cycle same-address read returns wr_data (write-first)
//   undefined : same-cycle same-address read returns the old word (read-first)
//   The array holds wr_data after the edge in both builds.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   wr_en     in   1      write strobe
//   wr_addr   in   AW     write word address
//   wr_data   in   WIDTH  write data
//   rd_en     in   1      read strobe
//   rd_addr   in   AW     read word address
//   rd_data   out  WIDTH  registered read data (holds while rd_en=0)
//   rd_valid  out  1      high for exactly the cycle after an accepted read
//   wr_err    out  1      last-cycle write address was >= DEPTH
//   rd_err    out  1      last-cycle read address was >= DEPTH
//
// Handshake: there is no ready. Every rd_en/wr_en sampled high on a rising
// edge is accepted on that edge; rd_valid marks the single cycle in which
// the matching rd_data is presented. Out-of-range reads still complete
// (rd_valid=1) with rd_data=0 and rd_err=1.
// ---------------------------------------------------------------------------
module regfile_mem
    import regmem_pkg::*;
#(
    parameter  int unsigned WIDTH = REGMEM_WIDTH,
    parameter  int unsigned DEPTH = REGMEM_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             wr_err,
    output logic             rd_err
);

    logic [WIDTH-1:0] words [DEPTH];
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_word;

    assign wr_ok = addr_ok(32'(wr_addr), DEPTH);
    assign rd_ok = addr_ok(32'(rd_addr), DEPTH);

    // Storage array: each word loads only when addressed by a write.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        regmem_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_en && (wr_addr == AW'(i))),
            .d     (wr_data),
            .q     (words[i])
        );
    end

    // Read mux. An out-of-range address matches no word and yields zero,
    // which is the data returned for an erroneous read.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_word = words[i];
            end
        end
`ifdef RD_BYPASS_EN
        // Write-first: forward the word being written this cycle.
        if (wr_en && wr_ok && rd_ok && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
`endif
    end

    // Read register and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data <= rd_word;
            end
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            wr_err   <= wr_en && !wr_ok;
        end
    end

endmodule : regfile_mem

// File: tb/tb_regfile_mem.sv
// ---------------------------------------------------------------------------
// tb_regfile_mem
//   Directed self-checking bench for regfile_mem at WIDTH=8, DEPTH=12.
//   Honors RD_BYPASS_EN for the same-address collision expectation.
// ---------------------------------------------------------------------------
module tb_regfile_mem;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             wr_err;
    logic             rd_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    regfile_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_err   (wr_err),
        .rd_err   (rd_err)
    );

    // ---------------- scoreboard ----------------
    int unsigned      n_checks = 0;
    int unsigned      n_pass   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    // Single read; checks data, valid and error flag one cycle later.
    task automatic do_read(input string tag, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] want);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        check_eq({tag, "_data"}, 32'(rd_data), 32'(want));
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_eq({tag, "_err"}, 32'(rd_err), (a >= DEPTH) ? 32'd1 : 32'd0);
    endtask

    // Back-to-back reads of every word, compared against the model queue.
    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            step();
            check_eq($sformatf("%s_data%0d", tag, i), 32'(rd_data),
                     32'(exp_q.pop_front()));
            check_eq($sformatf("%s_valid%0d", tag, i), 32'(rd_valid), 32'd1);
        end
        rd_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset held across an edge.
        step();
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);
        check_eq("rst_rd_err", 32'(rd_err), 32'd0);
        #3 rst_n = 1'b1;
        do_read("rst_word0", 4'd0, 8'h00);

        // 1. Pattern write then back-to-back read.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 8'hA0 + 8'(i));
        read_all("pat");

        // 2. Out-of-range write: flag for one cycle, array untouched.
        do_write(4'd13, 8'h55);
        check_eq("oor_wr_err", 32'(wr_err), 32'd1);
        step();
        check_eq("oor_wr_err_clear", 32'(wr_err), 32'd0);
        do_read("oor_rd", 4'd13, 8'h00);
        step();
        check_eq("oor_rd_err_clear", 32'(rd_err), 32'd0);
        read_all("oor_keep");

        // 3. Same-cycle same-address collision.
        do_write(4'd3, 8'h11);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'h22;
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        model[3] = 8'h22;
`ifdef RD_BYPASS_EN
        check_eq("coll_data", 32'(rd_data), 32'h22);
`else
        check_eq("coll_data", 32'(rd_data), 32'h11);
`endif
        check_eq("coll_valid", 32'(rd_valid), 32'd1);
        do_read("coll_after", 4'd3, 8'h22);

        // 4. Read hold with rd_en low.
        do_read("hold_rd", 4'd5, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("hold_data%0d", i), 32'(rd_data), 32'hA5);
            check_eq($sformatf("hold_valid%0d", i), 32'(rd_valid), 32'd0);
        end

        // 6. Concurrent different-address traffic.
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h3C;
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        model[2] = 8'h3C;
        check_eq("conc_data", 32'(rd_data), 32'hA9);
        check_eq("conc_valid", 32'(rd_valid), 32'd1);
        do_read("conc_after", 4'd2, 8'h3C);

        // 5. Reset mid-stream, asserted between clock edges.
        do_write(4'd7, 8'hFF);
        wr_en   = 1'b1;
        wr_addr = 4'd14;
        wr_data = 8'h77;
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        step();
        check_eq("pre_rst_data", 32'(rd_data), 32'hFF);
        wr_addr = 4'd15;
        rd_addr = 4'd15;
        step();
        check_eq("pre_rst_wr_err", 32'(wr_err), 32'd1);
        check_eq("pre_rst_rd_err", 32'(rd_err), 32'd1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_wr_err", 32'(wr_err), 32'd0);
        check_eq("mid_rst_rd_err", 32'(rd_err), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        do_read("post_rst_word7", 4'd7, 8'h00);
        read_all("post_rst");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_mem
